voice_env_mixer: RTL
====================

// Module: voice_env_mixer
// PURPOSE
// - Per-voice envelope scaling and mixing stage between the sine-table BRAM reads and the pdm DAC.
// - Per request: captures NUM_VOICES offset-binary samples, each voice's envelope and an active mask.
// - A single time-multiplexed multiplier scales and accumulates the voices; the sum is normalised,
//   gain-shifted and saturated.
// - Emits one offset-binary sample for pdm dc_in, with a one-cycle valid strobe.
// PARAMETERS
// - NUM_VOICES   4   voices mixed per request; power of 2, >=2
// - SAMPLE_WIDTH 16  BRAM sample width; offset binary, midpoint 2^(SAMPLE_WIDTH-1)
// - ENV_WIDTH    16  envelope width; unsigned Q0.ENV_WIDTH (0xFFFF ~= 1.0)
// - GAIN_SHIFT   0   left shift applied after normalisation, 0..4
// PORTS
// - clk_in     in   1                        system clock, 100 MHz
// - rst_in     in   1                        synchronous active-high reset
// - valid_in   in   1                        request strobe; samples ports below
// - sample_in  in   [NUM_VOICES][SAMPLE_WIDTH] per-voice BRAM samples
// - env_in     in   [NUM_VOICES][ENV_WIDTH]    per-voice ADSR envelopes
// - active_in  in   NUM_VOICES               voice enable mask; bit i gates voice i
// - busy_out   out  1                        high from capture through the NORM state
// - valid_out  out  1                        one-cycle pulse; mix_out updated this cycle
// - mix_out    out  SAMPLE_WIDTH             mixed offset-binary sample, held between pulses
// - clip_out   out  1                        high with valid_out when saturation occurred
// - dropped_out out 1                        one-cycle pulse when valid_in is ignored (busy)
// BEHAVIOUR
// - Reset values: mix_out=0x8000, valid_out=0, busy_out=0, clip_out=0, dropped_out=0.
//   FSM goes to IDLE and the accumulator clears.
// - FSM states: IDLE -> MAC -> NORM -> OUT -> IDLE.
// - IDLE, valid_in=1: latch sample_in/env_in/active_in, clear acc, idx=0, go to MAC.
//   busy_out rises on the next cycle.
// - MAC, one voice per cycle:
//   - s = sample ^ MSB (signed)
//   - p = (s * env) >>> ENV_WIDTH (signed, SAMPLE_WIDTH+1 bits)
//   - acc += active[idx] ? p : 0
//   - Accumulator is signed, SAMPLE_WIDTH+1+$clog2(NUM_VOICES) bits; it never overflows.
//   - idx wraps to 0 after NUM_VOICES-1; then go to NORM.
// - NORM: n = (acc >>> NSHIFT) <<< GAIN_SHIFT in a widened signed value.
//   - Saturate to [-2^(SW-1), 2^(SW-1)-1]; clip_next = saturated.
// - OUT: mix_out = sat ^ MSB, valid_out=1, clip_out=clip_next, busy_out=0; return to IDLE.
//   - clip_out clears on the next cycle.
// - Latency: valid_in at edge 0 -> valid_out at edge NUM_VOICES+2 (6 for defaults).
//   - Throughput: one request per NUM_VOICES+3 cycles.
// - valid_in outside IDLE is ignored, and dropped_out pulses in that cycle.
//   - valid_in in the OUT cycle is also dropped.
// - Input ports are sampled only at capture; changes mid-operation have no effect.
// - active_in all zero: result is exactly midpoint 0x8000, clip_out=0.
// - rst_in mid-operation: abort with no valid_out; all outputs return to reset values the next cycle.
// CONFIGURATION
// - VOICE_MIXER_AGC_EN defined: NSHIFT = ceil(log2(popcount(active mask))).
//   - Mask counts 0/1 -> 0, 2 -> 1, 3..4 -> 2.
//   - Popcount is computed at capture.
// - VOICE_MIXER_AGC_EN undefined: NSHIFT = $clog2(NUM_VOICES), a constant.
//   - No popcount logic is built.
// TESTING
// - Reset: assert rst_in for 2 cycles.
//   -> mix_out=0x8000, valid_out=0, busy_out=0, clip_out=0.
// - Single voice: voice0 sample=0xC000, env=0xFFFF, active=4'b0001.
//   -> p=16383; fixed mix_out=0x8FFF; AGC mix_out=0xBFFF; valid_out at edge 6.
// - Negative voice: voice1 sample=0x4000, env=0x8000, active=4'b0010.
//   -> p=-8192; fixed mix_out=0x7800; AGC mix_out=0x6000.
// - Clip: GAIN_SHIFT=2, all samples=0xFFFF, all env=0xFFFF, active=4'b1111.
//   -> fixed mode: acc=131064; mix_out=0xFFFF, clip_out=1 for one cycle.
// - Overlap: valid_in at edges 0 and 2.
//   -> dropped_out pulses at edge 2; exactly one valid_out, at edge 6.
//   - Back-to-back accepted requests spaced 7 cycles apart both complete.
// - Abort: valid_in at edge 0, rst_in at edge 3.
//   -> no valid_out; mix_out=0x8000 and busy_out=0 from edge 4; a new request then completes normally.

Source files
------------

// File: rtl/voice_env_mixer.sv
// Envelope-scaling voice mixer: one shared multiplier scales and sums NUM_VOICES samples per request.
// Define VOICE_MIXER_AGC_EN to normalise by the active voice count instead of NUM_VOICES.
module voice_env_mixer #(
    parameter int unsigned NUM_VOICES   = 4,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned ENV_WIDTH    = 16,
    parameter int unsigned GAIN_SHIFT   = 0
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     valid_in,
    input  logic [NUM_VOICES-1:0][SAMPLE_WIDTH-1:0]  sample_in,
    input  logic [NUM_VOICES-1:0][ENV_WIDTH-1:0]     env_in,
    input  logic [NUM_VOICES-1:0]                    active_in,
    output logic                                     busy_out,
    output logic                                     valid_out,
    output logic [SAMPLE_WIDTH-1:0]                  mix_out,
    output logic                                     clip_out,
    output logic                                     dropped_out
);

    localparam int unsigned SW  = SAMPLE_WIDTH;
    localparam int unsigned EW  = ENV_WIDTH;
    localparam int unsigned IW  = $clog2(NUM_VOICES);
    localparam int unsigned AW  = SW + 1 + IW;
    localparam int unsigned NW  = AW + 4;
    localparam int unsigned PW  = SW + EW + 1;
    localparam int unsigned SHW = $clog2(IW + 1);
    localparam logic [SW-1:0] MID = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [NW-1:0] SAT_MAX = NW'((64'd1 << (SW - 1)) - 64'd1);
    localparam logic signed [NW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_NORM, S_OUT} state_t;

    state_t                            state_q, state_d;
    logic [IW-1:0]                     idx_q, idx_d;
    logic signed [AW-1:0]              acc_q, acc_d;
    logic [NUM_VOICES-1:0][SW-1:0]     smp_q, smp_d;
    logic [NUM_VOICES-1:0][EW-1:0]     env_q, env_d;
    logic [NUM_VOICES-1:0]             act_q, act_d;
    logic [SW-1:0]                     sat_q, sat_d;
    logic                              clip_nx_q, clip_nx_d;
    logic [SW-1:0]                     mix_q, mix_d;
    logic                              valid_q, valid_d;
    logic                              busy_q, busy_d;
    logic                              clip_q, clip_d;
    logic                              drop_q, drop_d;
    logic [SHW-1:0]                    nshift_c;

    logic signed [SW-1:0]              s_c;
    logic signed [PW-1:0]              prod_c;
    logic signed [SW:0]                p_c;
    logic signed [AW-1:0]              addend_c;
    logic signed [NW-1:0]              n_c;
    logic [SW-1:0]                     sat_c;
    logic                              clip_c;

`ifdef VOICE_MIXER_AGC_EN
    logic [SHW-1:0] nshift_q, nshift_d;

    // ceil(log2(popcount)), with counts 0 and 1 both mapping to 0
    function automatic logic [SHW-1:0] pop_shift(input logic [NUM_VOICES-1:0] m);
        int unsigned    cnt;
        logic [SHW-1:0] r;
        cnt = 0;
        for (int i = 0; i < int'(NUM_VOICES); i++) cnt += 32'(m[i]);
        r = '0;
        for (int k = 0; k < int'(IW); k++) begin
            if ((32'd1 << k) < cnt) r = SHW'(k + 1);
        end
        return r;
    endfunction

    assign nshift_c = nshift_q;
    assign nshift_d = (state_q == S_IDLE && valid_in) ? pop_shift(active_in) : nshift_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) nshift_q <= '0;
        else        nshift_q <= nshift_d;
    end
`else
    assign nshift_c = SHW'(IW);
`endif

    // Shared multiplier, accumulate term and normalise/saturate path
    always_comb begin
        s_c      = $signed(smp_q[idx_q] ^ MID);
        prod_c   = PW'(s_c) * PW'($signed({1'b0, env_q[idx_q]}));
        p_c      = (SW + 1)'(prod_c >>> EW);
        addend_c = act_q[idx_q] ? AW'(p_c) : '0;
        n_c      = (NW'(acc_q) >>> nshift_c) <<< GAIN_SHIFT;
        clip_c   = 1'b0;
        sat_c    = SW'(n_c);
        if (n_c > SAT_MAX) begin
            sat_c  = SW'(SAT_MAX);
            clip_c = 1'b1;
        end else if (n_c < SAT_MIN) begin
            sat_c  = SW'(SAT_MIN);
            clip_c = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        smp_d     = smp_q;
        env_d     = env_q;
        act_d     = act_q;
        sat_d     = sat_q;
        clip_nx_d = clip_nx_q;
        mix_d     = mix_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        clip_d    = 1'b0;
        drop_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    smp_d   = sample_in;
                    env_d   = env_in;
                    act_d   = active_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                drop_d = valid_in;
                acc_d  = acc_q + addend_c;
                if (idx_q == IW'(NUM_VOICES - 1)) begin
                    idx_d   = '0;
                    state_d = S_NORM;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_NORM: begin
                drop_d    = valid_in;
                sat_d     = sat_c;
                clip_nx_d = clip_c;
                busy_d    = 1'b0;
                state_d   = S_OUT;
            end
            S_OUT: begin
                drop_d  = valid_in;
                mix_d   = sat_q ^ MID;
                valid_d = 1'b1;
                clip_d  = clip_nx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            smp_q     <= '0;
            env_q     <= '0;
            act_q     <= '0;
            sat_q     <= '0;
            clip_nx_q <= 1'b0;
            mix_q     <= MID;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            clip_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            smp_q     <= smp_d;
            env_q     <= env_d;
            act_q     <= act_d;
            sat_q     <= sat_d;
            clip_nx_q <= clip_nx_d;
            mix_q     <= mix_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            clip_q    <= clip_d;
            drop_q    <= drop_d;
        end
    end

    assign busy_out    = busy_q;
    assign valid_out   = valid_q;
    assign mix_out     = mix_q;
    assign clip_out    = clip_q;
    assign dropped_out = drop_q;

endmodule
